// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one instruction-bus request at a
// time and feeds decode through a registered F->D stage. ireq = {valid, addr[31:0]},
// iresp = {addr_ok, data_ok, data[31:0]}.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [32:0] ireq,
    input  logic [33:0] iresp,
    output logic [31:0] pc_o,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] instr_d_n, pc_d_n;
    logic        discard, discard_n;
    logic        valid_d_n;
    logic        take, from_buf;
    logic        addr_ok, data_ok;
    logic [31:0] data;

    assign {addr_ok, data_ok, data} = iresp;
    assign ireq      = {(state == S_REQ) && resetn, req_addr};
    assign pc_o      = pc;
    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_addr_n  = req_addr;
        discard_n   = discard;
        buf_instr_n = buf_instr;
        buf_pc_n    = buf_pc;
        valid_d_n   = stall ? valid_d : 1'b0;
        instr_d_n   = instr_d;
        pc_d_n      = pc_d;
        take        = 1'b0;
        from_buf    = 1'b0;

        // A flushed or previously discarded return is dropped instead of taken.
        case (state)
            S_REQ: begin
                if (addr_ok) begin
                    if (!data_ok) begin
                        state_n = S_WAIT;
                        if (flush) discard_n = 1'b1;
                    end else if (discard || flush) begin
                        discard_n = 1'b0;
                        state_n   = S_REQ;
                    end else begin
                        take = 1'b1;
                    end
                end else if (flush) begin
                    discard_n = 1'b1;
                end
            end
            S_WAIT: begin
                if (data_ok) begin
                    if (discard || flush) begin
                        discard_n = 1'b0;
                        state_n   = S_REQ;
                    end else begin
                        take = 1'b1;
                    end
                end else if (flush) begin
                    discard_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_n = S_REQ;
                end else if (!stall) begin
                    from_buf = 1'b1;
                    state_n  = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase

        if (take) begin
            if (stall) begin
                buf_instr_n = data;
                buf_pc_n    = req_addr;
                state_n     = S_HOLD;
            end else begin
                valid_d_n = 1'b1;
                instr_d_n = data;
                pc_d_n    = req_addr;
                pc_n      = next_pc;
                state_n   = S_REQ;
            end
        end

        if (from_buf) begin
            valid_d_n = 1'b1;
            instr_d_n = buf_instr;
            pc_d_n    = buf_pc;
            pc_n      = next_pc;
        end

        if (flush) begin
            valid_d_n = 1'b0;
            pc_n      = flush_pc;
        end

        // A fresh request starts whenever REQ is (re)entered; an unaccepted one keeps its address.
        if (state_n == S_REQ && (state != S_REQ || addr_ok)) req_addr_n = pc_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            discard   <= 1'b0;
            buf_instr <= 32'h0;
            buf_pc    <= 32'h0;
            valid_d   <= 1'b0;
            instr_d   <= 32'h0;
            pc_d      <= 32'h0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            discard   <= discard_n;
            buf_instr <= buf_instr_n;
            buf_pc    <= buf_pc_n;
            valid_d   <= valid_d_n;
            instr_d   <= instr_d_n;
            pc_d      <= pc_d_n;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a transaction-level model (accepted-request and
// parked-instruction queues) checked every cycle, plus hand-computed literal checks.
module tb_ifetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [32:0] ireq;
    logic [33:0] iresp;
    logic [31:0] pc_o, next_pc, instr_d, pc_d;
    logic        valid_d;
    logic [1:0]  state_dbg;
    logic        a_ok = 1'b0, d_ok = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] slave_addr = 32'h0;
    logic [31:0] resp_data;
    logic        chk_en = 1'b0;
    int          tests = 0, fails = 0;

    ifetch_ctrl dut (
        .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp), .pc_o(pc_o),
        .next_pc(next_pc), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Bus slave: instruction word is the inverted address it was fetched from.
    assign next_pc   = pc_o + 32'd4;
    assign resp_data = ireq[32] ? ~ireq[31:0] : ~slave_addr;
    assign iresp     = {a_ok, d_ok, resp_data};
    always @(posedge clk) if (ireq[32] && a_ok) slave_addr <= ireq[31:0];

    // ---------------- model ----------------
    typedef struct { logic [31:0] addr; logic drop; } txn_t;
    txn_t        inflight[$];
    logic [31:0] parked[$];
    logic [31:0] m_pc, m_req_addr, m_id, m_pd;
    logic        m_req_drop, m_vd;

    task automatic model_reset();
        inflight.delete();
        parked.delete();
        m_pc = RST_PC; m_req_addr = RST_PC; m_req_drop = 1'b0;
        m_vd = 1'b0; m_id = 32'h0; m_pd = 32'h0;
    endtask

    task automatic deliver(input logic [31:0] addr);
        m_vd = 1'b1; m_id = ~addr; m_pd = addr; m_pc = m_pc + 32'd4;
    endtask

    task automatic model_step();
        txn_t ret;
        bit   have_ret, presenting, accepted;
        have_ret = 0; accepted = 0;
        ret = '{32'h0, 1'b0};
        presenting = (inflight.size() == 0) && (parked.size() == 0);
        if (presenting && d_ok && !a_ok) begin
            fails++;
            $display("FAIL bus_protocol: data_ok=1 addr_ok=0 while a request is open");
        end
        if (presenting && a_ok) begin
            accepted = 1;
            if (d_ok) begin ret = '{m_req_addr, m_req_drop}; have_ret = 1; end
            else inflight.push_back('{m_req_addr, m_req_drop});
        end else if (!presenting && inflight.size() > 0 && d_ok) begin
            ret = inflight.pop_front();
            have_ret = 1;
        end
        if (flush) begin
            foreach (inflight[i]) inflight[i].drop = 1'b1;
            parked.delete();
            if (presenting && !accepted) m_req_drop = 1'b1;
            m_vd = 1'b0;
            m_pc = flush_pc;
        end else if (have_ret && !ret.drop) begin
            if (stall) parked.push_back(ret.addr);
            else deliver(ret.addr);
        end else if (parked.size() > 0 && !stall) begin
            deliver(parked.pop_front());
        end else if (!stall) begin
            m_vd = 1'b0;
        end
        if (inflight.size() == 0 && parked.size() == 0 && !(presenting && !accepted)) begin
            m_req_addr = m_pc;
            m_req_drop = 1'b0;
        end
    endtask

    initial model_reset();
    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic cmp_v;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_v = resetn && inflight.size() == 0 && parked.size() == 0;
            chk("m_ireq_valid", 32'(ireq[32]), 32'(cmp_v));
            if (cmp_v || !resetn) chk("m_ireq_addr", ireq[31:0], m_req_addr);
            chk("m_pc_o", pc_o, m_pc);
            chk("m_valid_d", 32'(valid_d), 32'(m_vd));
            if (m_vd || !resetn) begin
                chk("m_instr_d", instr_d, m_id);
                chk("m_pc_d", pc_d, m_pd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic a, input logic d, input logic s, input logic f,
                         input logic [31:0] fp = 32'h0);
        @(negedge clk);
        #1;
        a_ok = a; d_ok = d; stall = s; flush = f; flush_pc = fp;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ireq_valid"}, 32'(ireq[32]), 32'h0);
        chk({tag, "_ireq_addr"}, ireq[31:0], RST_PC);
        chk({tag, "_pc_o"}, pc_o, RST_PC);
        chk({tag, "_valid_d"}, 32'(valid_d), 32'h0);
        chk({tag, "_instr_d"}, instr_d, 32'h0);
        chk({tag, "_pc_d"}, pc_d, 32'h0);
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2 resetn = 1'b0;
        #1 chk_reset_values("reset");
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Release into an always-ready bus: one instruction per cycle.
        @(negedge clk);
        #1;
        resetn = 1'b1; a_ok = 1'b1; d_ok = 1'b1;
        #1 chk("rel_ireq_valid", 32'(ireq[32]), 32'h1);
        chk("rel_ireq_addr", ireq[31:0], RST_PC);
        after_edge();
        chk("t1_pc_d0", pc_d, 32'hBFC0_0000);
        chk("t1_instr_d0", instr_d, 32'h403F_FFFF);
        for (int k = 1; k < 3; k++) begin
            drive(1, 1, 0, 0);
            after_edge();
            chk("t1_pc_d", pc_d, 32'hBFC0_0000 + 32'(4 * k));
            chk("t1_valid_d", 32'(valid_d), 32'h1);
        end

        // Split handshake: data one cycle after address, bubble in between.
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0);
            after_edge();
            chk("t2_bubble", 32'(valid_d), 32'h0);
            drive(0, 1, 0, 0);
            after_edge();
            chk("t2_pc_d", pc_d, 32'hBFC0_000C + 32'(4 * k));
            chk("t2_valid_d", 32'(valid_d), 32'h1);
        end

        // Data returns under a 3-cycle stall: HOLD, then the buffered instruction.
        drive(1, 1, 1, 0);
        after_edge();
        chk("t3_no_req", 32'(ireq[32]), 32'h0);
        chk("t3_pc_d_held", pc_d, 32'hBFC0_0010);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 0);
            after_edge();
            chk("t3_instr_held", instr_d, 32'h403F_FFEF);
            chk("t3_no_req2", 32'(ireq[32]), 32'h0);
        end
        drive(0, 0, 0, 0);
        after_edge();
        chk("t3_buf_pc_d", pc_d, 32'hBFC0_0014);
        chk("t3_buf_valid", 32'(valid_d), 32'h1);
        chk("t3_next_addr", ireq[31:0], 32'hBFC0_0018);

        // Flush while waiting for data.
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h8000_0100);
        after_edge();
        chk("t4_pc_o", pc_o, 32'h8000_0100);
        drive(0, 1, 0, 0);
        after_edge();
        chk("t4_dropped", 32'(valid_d), 32'h0);
        chk("t4_addr", ireq[31:0], 32'h8000_0100);
        drive(1, 1, 0, 0);
        after_edge();
        chk("t4_pc_d", pc_d, 32'h8000_0100);
        chk("t4_instr_d", instr_d, 32'h7FFF_FEFF);

        // Flush while the request is not yet accepted: address must not move.
        drive(0, 0, 0, 1, 32'h9000_0000);
        after_edge();
        chk("t5_addr_held", ireq[31:0], 32'h8000_0104);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0);
            after_edge();
            chk("t5_addr_held2", ireq[31:0], 32'h8000_0104);
        end
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        after_edge();
        chk("t5_dropped", 32'(valid_d), 32'h0);
        chk("t5_addr", ireq[31:0], 32'h9000_0000);
        drive(1, 1, 0, 0);
        after_edge();
        chk("t5_pc_d", pc_d, 32'h9000_0000);

        // Flush together with stall while holding a buffered instruction.
        drive(1, 1, 1, 0);
        drive(0, 0, 1, 1, 32'hA000_0000);
        after_edge();
        chk("t6_valid_d", 32'(valid_d), 32'h0);
        chk("t6_req", 32'(ireq[32]), 32'h1);
        chk("t6_addr", ireq[31:0], 32'hA000_0000);
        drive(1, 1, 1, 0);
        after_edge();
        chk("t6_stalled", 32'(valid_d), 32'h0);
        drive(0, 0, 0, 0);
        after_edge();
        chk("t6_pc_d", pc_d, 32'hA000_0000);

        // Flush in REQ with full handshake, then with address-only acceptance.
        drive(1, 1, 0, 1, 32'hB000_0000);
        after_edge();
        chk("t7_addr", ireq[31:0], 32'hB000_0000);
        chk("t7_valid_d", 32'(valid_d), 32'h0);
        drive(1, 1, 0, 0);
        after_edge();
        chk("t7_pc_d", pc_d, 32'hB000_0000);
        drive(1, 0, 0, 1, 32'hC000_0000);
        drive(0, 1, 0, 0);
        after_edge();
        chk("t8_addr", ireq[31:0], 32'hC000_0000);
        chk("t8_valid_d", 32'(valid_d), 32'h0);
        drive(1, 1, 0, 0);
        after_edge();
        chk("t8_pc_d", pc_d, 32'hC000_0000);

        // Mid-operation asynchronous reset while a request is in flight.
        drive(1, 0, 0, 0);
        @(negedge clk);
        #2;
        a_ok = 1'b0; d_ok = 1'b0; resetn = 1'b0;
        #1 chk_reset_values("midreset");
        @(negedge clk);
        #1;
        resetn = 1'b1; a_ok = 1'b1; d_ok = 1'b1;
        after_edge();
        chk("t9_pc_d", pc_d, 32'hBFC0_0000);
        drive(1, 1, 0, 0);
        after_edge();
        chk("t9_pc_d2", pc_d, 32'hBFC0_0004);

        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller sitting between the PC/next-PC logic and the decode stage. It owns the architectural PC register, drives the instruction bus (`ibus_req_t` / `ibus_resp_t`) with one outstanding request at a time, and presents fetched instructions to decode through a registered F→D boundary. It also absorbs decode back-pressure (`stall`) and pipeline redirects (`flush`).

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: PC value loaded on reset.
- `clk`  in  1: clock; all state changes on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `ireq`  out  `ibus_req_t`: `valid`, `addr`.
- `iresp`  in  `ibus_resp_t`: `addr_ok`, `data_ok`, `data[31:0]`.
- `pc_o`  out  32: current fetch PC, fed to the next-PC logic.
- `next_pc`  in  32: next sequential or branch target, computed combinationally from `pc_o`.
- `stall`  in  1: decode cannot accept a new instruction this cycle.
- `flush`  in  1: redirect the fetch stream to `flush_pc`.
- `flush_pc`  in  32: redirect target.
- `valid_d`  out  1: the F→D register holds a valid instruction.
- `instr_d`  out  32: instruction in the F→D register.
- `pc_d`  out  32: PC of `instr_d`.

## Operation
- Registers:
  - `pc`: 32 bits.
  - `req_addr`: 32 bits; the address held stable while the request is in flight.
  - State machine: REQ / WAIT / HOLD.
  - `discard`: 1 bit.
  - `buf_instr` / `buf_pc`: 32 bits each.
  - F→D register: `valid_d`, `instr_d`, `pc_d`.
- `ireq.valid = (state==REQ) && resetn`.
- `ireq.addr = req_addr`. `req_addr` is loaded with the new `pc` on every transition into REQ.
- `pc_o = pc`.
- "Complete" means the returned data is accepted (not discarded). On complete:
  - If `!stall`: `instr_d <= data`, `pc_d <= req_addr`, `valid_d <= 1`, `pc <= next_pc`, next state REQ.
  - If `stall`: `buf_instr <= data`, `buf_pc <= req_addr`, next state HOLD; `pc` unchanged.
- State transitions:
  - REQ, `addr_ok && data_ok`: complete.
  - REQ, `addr_ok` only: go to WAIT.
  - REQ, neither: stay in REQ with `addr` unchanged.
  - WAIT: `ireq.valid=0`. On `data_ok`: if `discard`, drop the data, clear `discard`, go to REQ; otherwise complete.
  - HOLD: no bus activity. On `!stall`: load the F→D register from the buffer, `pc <= next_pc`, go to REQ.
- F→D register when nothing new is loaded:
  - `stall=1`: hold the contents.
  - `stall=0`: `valid_d <= 0` (bubble).
- Flush (priority over `stall` and over completion):
  - Always: `valid_d <= 0`, `pc <= flush_pc`.
  - In REQ without `addr_ok`: the request must not be retracted. `addr` is held, `discard <= 1`, and the data is dropped when it returns.
  - In REQ with `addr_ok` (no `data_ok`): `discard <= 1`, go to WAIT.
  - In REQ with `addr_ok && data_ok`: drop the data, go to REQ; `req_addr <= flush_pc`.
  - In WAIT: `discard <= 1`; if `data_ok` arrives the same cycle, drop it and go to REQ.
  - In HOLD: drop the buffer, go to REQ.
- Never more than one outstanding request. `data_ok` in REQ without `addr_ok` is a bus protocol error; the bench asserts it never occurs.

## Timing
- Reset (async assert, sync release):
  - Outputs: `ireq.valid=0`, `ireq.addr=RESET_PC`, `pc_o=RESET_PC`, `valid_d=0`, `instr_d=0`, `pc_d=0`.
  - State: REQ, `discard=0`, buffers 0.
- First edge after release: `ireq.valid=1` with `addr=RESET_PC` is visible in that same cycle.
- Throughput and latency:
  - `addr_ok`+`data_ok` in the same cycle: 1 instruction/cycle. `valid_d` rises on the edge after the handshake cycle.
  - `data_ok` one cycle after `addr_ok`: 2 cycles per instruction.
- Flush takes effect at the edge it is sampled. The first request to `flush_pc` issues the next cycle if the bus is idle; otherwise it issues in the cycle after the discarded `data_ok`.
- Mid-operation reset returns everything to reset values immediately. A late `data_ok` after reset must be ignored; `discard` is not set by reset, and the bench never issues one.

## Test plan
- Reset release, always-ready bus (`addr_ok=data_ok=1`, data = addr^`32'hFFFF_FFFF`), `next_pc = pc+4` → `pc_d` = BFC00000, BFC00004, BFC00008 on consecutive cycles; `valid_d` continuous from cycle 2.
- `addr_ok` in cycle N, `data_ok` in cycle N+1 → `valid_d` pulses every other cycle, with a bubble (`valid_d=0`) between instructions.
- Data returns while `stall=1` for 3 cycles → HOLD entered. `instr_d` holds its previous value, with no bus request, until `stall` drops; then the buffered instruction appears and the next request issues.
- `flush` with `flush_pc=32'h8000_0100` while in WAIT → the old `data_ok` is dropped (`valid_d` stays 0); the next `ireq.addr=8000_0100`; `pc_d` of the first valid instruction is `8000_0100`.
- `flush` in REQ while `addr_ok=0` for 2 more cycles → `ireq.addr` stays at the old value until `addr_ok`, its data is discarded, then a request to `flush_pc` issues.
- `flush` and `stall` together in HOLD → the buffer is dropped, `valid_d=0`, and the next request goes to `flush_pc` regardless of `stall`.
